td4_core: RTL and testbench

TD4_CORE -- requirements
Module: td4_core

---
 rtl/td4_defs.sv | 29 ++
 rtl/td4_core_if.sv | 11 +
 rtl/td4_alu.sv | 14 +
 rtl/td4_core.sv | 107 ++++++++++
 tb/tb_td4_core.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/td4_defs.sv
// Shared definitions for the TD4 core: opcode constants, instruction layout
// and the sequential program-counter step.
package td4_defs;

    localparam logic [3:0] OP_ADD_A    = 4'b0000;
    localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
    localparam logic [3:0] OP_IN_A     = 4'b0010;
    localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
    localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
    localparam logic [3:0] OP_ADD_B    = 4'b0101;
    localparam logic [3:0] OP_IN_B     = 4'b0110;
    localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
    localparam logic [3:0] OP_OUT_B    = 4'b1001;
    localparam logic [3:0] OP_OUT_IM   = 4'b1011;
    localparam logic [3:0] OP_JNC      = 4'b1110;
    localparam logic [3:0] OP_JMP      = 4'b1111;

    // Instruction word as fetched from the program ROM.
    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] imm;
    } instr_t;

    // Sequential fetch: PC+1, wrapping 15 -> 0 through the 4-bit width.
    function automatic logic [3:0] pc_step(input logic [3:0] pc);
        return pc + 4'd1;
    endfunction

endpackage

// File: rtl/td4_core_if.sv
// Program-ROM bus: the core drives the address, the ROM returns the
// instruction word combinationally in the same cycle.
interface td4_core_if;

    logic [3:0] address;
    logic [7:0] instr;

    modport master (output address, input instr);
    modport slave  (input address, output instr);

endinterface

// File: rtl/td4_alu.sv
// TD4 adder: 4-bit operand plus immediate, producing a 4-bit sum and carry.
module td4_alu (
    input  logic [3:0] opnd,
    input  logic [3:0] imm,
    output logic [3:0] sum,
    output logic       carry
);

    // Five-bit add; bit 4 becomes the carry flag.
    always_comb begin
        {carry, sum} = {1'b0, opnd} + {1'b0, imm};
    end

endmodule

// File: rtl/td4_core.sv
// TD4 4-bit single-cycle CPU core: decode, program counter and register file.
// One instruction executes per rising CLK edge; the ROM is read combinationally
// from ADDRESS and returns INSTR in the same cycle.
module td4_core
    import td4_defs::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] INSTR,
    output logic [3:0] ADDRESS,
    input  logic [3:0] IN,
    output logic [3:0] OUT
);

    // Architectural state.
    logic [3:0] a_r;
    logic [3:0] b_r;
    logic [3:0] out_r;
    logic [3:0] pc_r;
    logic       c_r;

    // Next-state values from the decoder.
    logic [3:0] a_nxt_s;
    logic [3:0] b_nxt_s;
    logic [3:0] out_nxt_s;
    logic [3:0] pc_nxt_s;
    logic       c_nxt_s;

    // Decoded fields and adder signals.
    instr_t     instr_s;
    logic [3:0] alu_opnd_s;
    logic [3:0] alu_sum_s;
    logic       alu_carry_s;

    assign instr_s = instr_t'(INSTR);

    // ADD B is the only instruction that adds to B; every other add uses A.
    assign alu_opnd_s = (instr_s.opcode == OP_ADD_B) ? b_r : a_r;

    td4_alu u_alu (
        .opnd  (alu_opnd_s),
        .imm   (instr_s.imm),
        .sum   (alu_sum_s),
        .carry (alu_carry_s)
    );

    // Instruction decode: compute the next value of every state register.
    always_comb begin
        a_nxt_s   = a_r;
        b_nxt_s   = b_r;
        out_nxt_s = out_r;
        pc_nxt_s  = pc_step(pc_r);
        c_nxt_s   = 1'b0;
        case (instr_s.opcode)
            OP_ADD_A: begin
                a_nxt_s = alu_sum_s;
                c_nxt_s = alu_carry_s;
            end
            OP_ADD_B: begin
                b_nxt_s = alu_sum_s;
                c_nxt_s = alu_carry_s;
            end
            OP_MOV_A_IM: a_nxt_s   = instr_s.imm;
            OP_MOV_B_IM: b_nxt_s   = instr_s.imm;
            OP_MOV_A_B:  a_nxt_s   = b_r;
            OP_MOV_B_A:  b_nxt_s   = a_r;
            OP_IN_A:     a_nxt_s   = IN;
            OP_IN_B:     b_nxt_s   = IN;
            OP_OUT_B:    out_nxt_s = b_r;
            OP_OUT_IM:   out_nxt_s = instr_s.imm;
            OP_JMP:      pc_nxt_s  = instr_s.imm;
            OP_JNC: begin
                // The flag tested is the one left by the previous instruction.
                if (c_r == 1'b0) begin
                    pc_nxt_s = instr_s.imm;
                end else begin
                    pc_nxt_s = pc_step(pc_r);
                end
            end
            default: begin
                // Unassigned opcodes are NOPs: PC advances, carry clears.
                pc_nxt_s = pc_step(pc_r);
            end
        endcase
    end

    // State register: asynchronous clear, otherwise commit the decoded update.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            a_r   <= 4'd0;
            b_r   <= 4'd0;
            out_r <= 4'd0;
            pc_r  <= 4'd0;
            c_r   <= 1'b0;
        end else begin
            a_r   <= a_nxt_s;
            b_r   <= b_nxt_s;
            out_r <= out_nxt_s;
            pc_r  <= pc_nxt_s;
            c_r   <= c_nxt_s;
        end
    end

    assign ADDRESS = pc_r;
    assign OUT     = out_r;

endmodule

// File: tb/tb_td4_core.sv
// Directed self-checking bench for td4_core with a 16-entry program ROM
// attached through the ROM bus interface.
module tb_td4_core;
    import td4_defs::*;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] IN;
    logic [3:0] OUT;
    logic [7:0] rom [16];

    int n_cmp = 0;
    int n_bad = 0;

    td4_core_if rom_bus ();

    assign rom_bus.instr = rom[rom_bus.address];

    td4_core dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .INSTR   (rom_bus.instr),
        .ADDRESS (rom_bus.address),
        .IN      (IN),
        .OUT     (OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [3:0] a, input logic [3:0] b,
                               input logic c, input logic [3:0] pc, input logic [3:0] o);
        check({tag, ".A"}, dut.a_r, a);
        check({tag, ".B"}, dut.b_r, b);
        check({tag, ".C"}, {3'b000, dut.c_r}, {3'b000, c});
        check({tag, ".PC"}, rom_bus.address, pc);
        check({tag, ".OUT"}, OUT, o);
    endtask

    // One executing edge, then settle to the falling edge for sampling.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic fill_rom(input logic [7:0] v);
        for (int i = 0; i < 16; i++) rom[i] = v;
    endtask

    task automatic hold_reset();
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic release_reset();
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic load_blink();
        fill_rom(8'h80);
        rom[0] = 8'hB3; rom[1] = 8'hB6; rom[2] = 8'hBC; rom[3] = 8'hB8; rom[4] = 8'hB8;
        rom[5] = 8'hBC; rom[6] = 8'hB6; rom[7] = 8'hB3; rom[8] = 8'hB1; rom[9] = 8'hF0;
    endtask

    logic [3:0] blink_out [9] = '{4'h3, 4'h6, 4'hC, 4'h8, 4'h8, 4'hC, 4'h6, 4'h3, 4'h1};

    initial begin
        RESET = 1'b1;
        IN    = 4'h0;
        fill_rom(8'h80);

        // Reset state.
        @(negedge CLK);
        check_state("reset", 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);

        // Blink program: OUT follows the immediates, JMP returns to 0.
        hold_reset();
        load_blink();
        release_reset();
        for (int k = 0; k < 9; k++) begin
            step();
            check("blink_out", OUT, blink_out[k]);
            check("blink_pc", rom_bus.address, 4'(k + 1));
        end
        step();
        check("blink_jmp_pc", rom_bus.address, 4'h0);
        check("blink_jmp_out", OUT, 4'h1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("blink_rpt_out", OUT, blink_out[k]);
        end

        // Carry: MOV A,F; ADD A,1; JNC 5 (not taken).
        hold_reset();
        fill_rom(8'h80);
        rom[0] = {OP_MOV_A_IM, 4'hF};
        rom[1] = {OP_ADD_A, 4'h1};
        rom[2] = {OP_JNC, 4'h5};
        release_reset();
        step();
        check_state("carry_mov", 4'hF, 4'h0, 1'b0, 4'h1, 4'h0);
        step();
        check_state("carry_add", 4'h0, 4'h0, 1'b1, 4'h2, 4'h0);
        step();
        check_state("carry_jnc", 4'h0, 4'h0, 1'b0, 4'h3, 4'h0);

        // Taken JNC: MOV A,2; ADD A,1; JNC 7.
        hold_reset();
        fill_rom(8'h80);
        rom[0] = 8'h32; rom[1] = 8'h01; rom[2] = 8'hE7;
        release_reset();
        step();
        step();
        check_state("jnc_add", 4'h3, 4'h0, 1'b0, 4'h2, 4'h0);
        step();
        check_state("jnc_taken", 4'h3, 4'h0, 1'b0, 4'h7, 4'h0);

        // ADD B with carry out, then MOV A,B.
        hold_reset();
        fill_rom(8'h80);
        rom[0] = 8'h79; rom[1] = 8'h58; rom[2] = 8'h10;
        release_reset();
        step();
        step();
        check_state("addb", 4'h0, 4'h1, 1'b1, 4'h2, 4'h0);
        step();
        check_state("movab", 4'h1, 4'h1, 1'b0, 4'h3, 4'h0);

        // IN / MOV / OUT B.
        hold_reset();
        fill_rom(8'h80);
        rom[0] = 8'h20; rom[1] = 8'h40; rom[2] = 8'h90;
        IN = 4'b1010;
        release_reset();
        step();
        check_state("in_a", 4'hA, 4'h0, 1'b0, 4'h1, 4'h0);
        step();
        check_state("mov_ba", 4'hA, 4'hA, 1'b0, 4'h2, 4'h0);
        step();
        check_state("out_b", 4'hA, 4'hA, 1'b0, 4'h3, 4'hA);

        // PC wrap over an all-NOP ROM; registers hold their values.
        IN = 4'h5;
        fill_rom(8'h80);
        for (int k = 1; k <= 29; k++) begin
            step();
            check("wrap_pc", rom_bus.address, 4'(k + 3));
            check("wrap_a", dut.a_r, 4'hA);
        end
        check_state("wrap_end", 4'hA, 4'hA, 1'b0, 4'h0, 4'hA);

        // Asynchronous reset mid-blink, then restart from address 0.
        hold_reset();
        load_blink();
        release_reset();
        for (int k = 0; k < 4; k++) step();
        check_state("pre_rst", 4'h0, 4'h0, 1'b0, 4'h4, 4'h8);
        #2;
        RESET = 1'b1;
        #1;
        check_state("async_rst", 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        release_reset();
        step();
        check("restart_out", OUT, 4'h3);
        check("restart_pc", rom_bus.address, 4'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
